// File: rtl/vga_frame_reader.sv
// Prefetches the RGB565 framebuffer from SDRAM into a small pixel FIFO and
// serves one pixel per request to the VGA driver, flagging underflow.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              pixel_req,
  output logic [15:0]       pixel_data,
  output logic              pixel_valid,
  output logic              underflow,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic              rd_ready,
  input  logic [15:0]       rd_data,
  input  logic              rd_valid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t             state;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   discard;
  logic [CNT_W-1:0]   inflight_nxt;
  logic [SUM_W-1:0]   credit_used;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;

  // Credit: every word in the FIFO or still owed by SDRAM holds a FIFO slot.
  assign credit_used  = SUM_W'(fifo_count) + SUM_W'(inflight);
  assign rd_en        = (state == FETCH) && (credit_used < SUM_W'(FIFO_DEPTH)) && (discard == '0);
  assign accept       = rd_en && rd_ready;
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push         = rd_valid && (discard == '0) && !frame_start;
  assign pop          = pixel_req && !fifo_empty;
  assign inflight_nxt = inflight + CNT_W'(accept) - CNT_W'(rd_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_addr     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      inflight    <= '0;
      discard     <= '0;
      underflow   <= 1'b0;
      pixel_data  <= 16'h0000;
      pixel_valid <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (frame_start) begin
        // Words still owed for the old frame, including one accepted now, get dropped.
        state      <= FETCH;
        rd_addr    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        discard    <= inflight_nxt;
        underflow  <= 1'b0;
      end else begin
        if (accept) begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (rd_addr == LAST_ADDR) state <= DONE;
        end
        if (rd_valid && (discard != '0)) discard <= discard - CNT_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        if (pixel_req && fifo_empty) underflow <= 1'b1;
      end
      if (pixel_req) begin
        pixel_valid <= !fifo_empty;
        pixel_data  <= fifo_empty ? 16'h0000 : mem[rd_ptr];
      end else begin
        pixel_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full && !pop))
    else $error("vga_frame_reader: push into full pixel FIFO");

endmodule
